// File: rtl/bp_cce_gad_stream_if.sv
// Handshake and data bundle between the directory read path, the GAD engine
// and the CCE decode/flag stage. The engine is the slave; the surroundings are the master.
interface bp_cce_gad_stream_if #(
  parameter int lce_per_beat_p    = 2,
  parameter int lce_assoc_width_p = 3,
  parameter int lce_id_width_p    = 3
);
  logic                                   start_v_i;
  logic                                   start_ready_o;
  logic [lce_id_width_p-1:0]              req_lce_i;
  logic                                   req_type_flag_i;
  logic [2:0]                             lru_coh_state_i;
  logic                                   atomic_req_flag_i;
  logic                                   uncached_req_flag_i;

  logic                                   beat_v_i;
  logic                                   beat_ready_o;
  logic [lce_per_beat_p-1:0]              beat_hits_i;
  logic [lce_per_beat_p*lce_assoc_width_p-1:0] beat_ways_i;
  logic [lce_per_beat_p*3-1:0]            beat_states_i;

  logic                                   v_o;
  logic                                   yumi_i;
  logic [lce_assoc_width_p-1:0]           req_addr_way_o;
  logic [lce_id_width_p-1:0]              owner_lce_o;
  logic [lce_assoc_width_p-1:0]           owner_way_o;
  logic [2:0]                             owner_coh_state_o;
  logic                                   replacement_flag_o;
  logic                                   upgrade_flag_o;
  logic                                   cached_shared_flag_o;
  logic                                   cached_exclusive_flag_o;
  logic                                   cached_modified_flag_o;
  logic                                   cached_owned_flag_o;
  logic                                   cached_forward_flag_o;
  logic                                   multi_owner_error_o;

  modport slave (
    input  start_v_i, req_lce_i, req_type_flag_i, lru_coh_state_i,
           atomic_req_flag_i, uncached_req_flag_i,
           beat_v_i, beat_hits_i, beat_ways_i, beat_states_i, yumi_i,
    output start_ready_o, beat_ready_o, v_o, req_addr_way_o, owner_lce_o,
           owner_way_o, owner_coh_state_o, replacement_flag_o, upgrade_flag_o,
           cached_shared_flag_o, cached_exclusive_flag_o, cached_modified_flag_o,
           cached_owned_flag_o, cached_forward_flag_o, multi_owner_error_o
  );

  modport master (
    output start_v_i, req_lce_i, req_type_flag_i, lru_coh_state_i,
           atomic_req_flag_i, uncached_req_flag_i,
           beat_v_i, beat_hits_i, beat_ways_i, beat_states_i, yumi_i,
    input  start_ready_o, beat_ready_o, v_o, req_addr_way_o, owner_lce_o,
           owner_way_o, owner_coh_state_o, replacement_flag_o, upgrade_flag_o,
           cached_shared_flag_o, cached_exclusive_flag_o, cached_modified_flag_o,
           cached_owned_flag_o, cached_forward_flag_o, multi_owner_error_o
  );
endinterface

// File: rtl/bp_cce_gad_stream.sv
// Beat-serial GAD engine: folds per-LCE directory beats into hit/owner/cached-state
// summaries and presents the resulting flags on a valid/yumi output.
module bp_cce_gad_stream #(
  parameter int num_lce_p         = 8,
  parameter int lce_per_beat_p    = 2,
  parameter int lce_assoc_width_p = 3,
  parameter int lce_id_width_p    = 3
) (
  input logic              clk_i,
  input logic              reset_i,
  bp_cce_gad_stream_if.slave bus
);
  localparam int num_beats_lp = num_lce_p / lce_per_beat_p;
  localparam int cnt_w_lp     = (num_beats_lp > 1) ? $clog2(num_beats_lp) : 1;
  localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(num_beats_lp - 1);

  localparam logic [2:0] coh_i = 3'd0;
  localparam logic [2:0] coh_s = 3'd1;
  localparam logic [2:0] coh_e = 3'd2;
  localparam logic [2:0] coh_f = 3'd3;
  localparam logic [2:0] coh_m = 3'd6;
  localparam logic [2:0] coh_o = 3'd7;

  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, DONE = 2'd2} state_e;

  typedef struct packed {
    logic [lce_id_width_p-1:0] lce;
    logic                      store;
    logic [2:0]                lru;
    logic                      atomic;
    logic                      uncached;
  } req_t;

  typedef struct packed {
    logic                         req_cached;
    logic                         req_ro;
    logic [lce_assoc_width_p-1:0] req_way;
    logic [lce_id_width_p-1:0]    owner_lce;
    logic [lce_assoc_width_p-1:0] owner_way;
    logic [2:0]                   owner_state;
    logic                         cs, ce, cm, co, cf;
    logic                         multi;
    logic                         upgrade;
    logic                         replacement;
  } acc_t;

  state_e                state_q, state_d;
  logic [cnt_w_lp-1:0]   cnt_q, cnt_d;
  req_t                  req_q, req_d;
  acc_t                  acc_q, acc_d;

  logic [lce_id_width_p-1:0]    idx;
  logic [lce_assoc_width_p-1:0] way;
  logic [2:0]                   st;

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    acc_d   = acc_q;
    idx     = '0;
    way     = '0;
    st      = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.start_v_i) begin
          state_d        = COLLECT;
          cnt_d          = '0;
          req_d.lce      = bus.req_lce_i;
          req_d.store    = bus.req_type_flag_i;
          req_d.lru      = bus.lru_coh_state_i;
          req_d.atomic   = bus.atomic_req_flag_i;
          req_d.uncached = bus.uncached_req_flag_i;
          acc_d          = '0;
        end
      end

      COLLECT: begin
        if (bus.beat_v_i) begin
          // Ascending j keeps the first owner candidate at the lowest LCE index.
          for (int j = 0; j < lce_per_beat_p; j++) begin
            idx = lce_id_width_p'(cnt_q) * lce_id_width_p'(lce_per_beat_p)
                + lce_id_width_p'(j);
            way = bus.beat_ways_i[j*lce_assoc_width_p +: lce_assoc_width_p];
            st  = bus.beat_states_i[j*3 +: 3];
            if (bus.beat_hits_i[j]) begin
              if (idx == req_q.lce) begin
                acc_d.req_cached = 1'b1;
                acc_d.req_way    = way;
                acc_d.req_ro     = (st == coh_s) || (st == coh_f) || (st == coh_o);
              end else begin
                case (st)
                  coh_s:   acc_d.cs = 1'b1;
                  coh_e:   acc_d.ce = 1'b1;
                  coh_m:   acc_d.cm = 1'b1;
                  coh_o:   acc_d.co = 1'b1;
                  coh_f:   acc_d.cf = 1'b1;
                  default: ;
                endcase
              end
              if ((st == coh_e) || (st == coh_m) || (st == coh_o) || (st == coh_f)) begin
                // Owner states are never I, so I doubles as "no owner yet".
                if (acc_d.owner_state == coh_i) begin
                  acc_d.owner_lce   = idx;
                  acc_d.owner_way   = way;
                  acc_d.owner_state = st;
                end else begin
                  acc_d.multi = 1'b1;
                end
              end
            end
          end

          if (cnt_q == last_cnt_lp) begin
            state_d       = DONE;
            cnt_d         = '0;
            acc_d.upgrade = req_q.store & acc_d.req_ro & ~req_q.uncached;
            if (req_q.uncached | req_q.atomic)
              acc_d.replacement = acc_d.req_cached;
            else
              acc_d.replacement = ~acc_d.upgrade &
                ((req_q.lru == coh_e) || (req_q.lru == coh_m) || (req_q.lru == coh_o));
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      DONE: begin
        if (bus.yumi_i) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      acc_q   <= acc_d;
    end
  end

  assign bus.start_ready_o           = (state_q == IDLE);
  assign bus.beat_ready_o            = (state_q == COLLECT);
  assign bus.v_o                     = (state_q == DONE);
  assign bus.req_addr_way_o          = acc_q.req_way;
  assign bus.owner_lce_o             = acc_q.owner_lce;
  assign bus.owner_way_o             = acc_q.owner_way;
  assign bus.owner_coh_state_o       = acc_q.owner_state;
  assign bus.replacement_flag_o      = acc_q.replacement;
  assign bus.upgrade_flag_o          = acc_q.upgrade;
  assign bus.cached_shared_flag_o    = acc_q.cs;
  assign bus.cached_exclusive_flag_o = acc_q.ce;
  assign bus.cached_modified_flag_o  = acc_q.cm;
  assign bus.cached_owned_flag_o     = acc_q.co;
  assign bus.cached_forward_flag_o   = acc_q.cf;
  assign bus.multi_owner_error_o     = acc_q.multi;
endmodule

// File: tb/tb_bp_cce_gad_stream.sv
// Directed bench for bp_cce_gad_stream: 8 LCEs, 2 per beat, hand-computed expectations.
module tb_bp_cce_gad_stream;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  bp_cce_gad_stream_if #(.lce_per_beat_p(2), .lce_assoc_width_p(3), .lce_id_width_p(3)) bus ();

  bp_cce_gad_stream #(
    .num_lce_p(8), .lce_per_beat_p(2), .lce_assoc_width_p(3), .lce_id_width_p(3)
  ) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // flags = {shared, exclusive, modified, owned, forward}
  task automatic check_out(input string t, input logic v, input int raddr, input int olce,
                           input int oway, input int ost, input logic rep, input logic upg,
                           input logic [4:0] flags, input logic multi);
    check({t, "_v"},      bus.v_o, v);
    check({t, "_rway"},   bus.req_addr_way_o, raddr);
    check({t, "_olce"},   bus.owner_lce_o, olce);
    check({t, "_oway"},   bus.owner_way_o, oway);
    check({t, "_ost"},    bus.owner_coh_state_o, ost);
    check({t, "_rep"},    bus.replacement_flag_o, rep);
    check({t, "_upg"},    bus.upgrade_flag_o, upg);
    check({t, "_flags"},  {bus.cached_shared_flag_o, bus.cached_exclusive_flag_o,
                           bus.cached_modified_flag_o, bus.cached_owned_flag_o,
                           bus.cached_forward_flag_o}, flags);
    check({t, "_multi"},  bus.multi_owner_error_o, multi);
  endtask

  // Each stimulus task drives at the falling edge and returns 1 time unit after the rising edge.
  task automatic start_req(input int lce, input logic store, input int lru,
                           input logic atomic, input logic unc);
    @(negedge clk);
    bus.start_v_i           = 1'b1;
    bus.req_lce_i           = 3'(lce);
    bus.req_type_flag_i     = store;
    bus.lru_coh_state_i     = 3'(lru);
    bus.atomic_req_flag_i   = atomic;
    bus.uncached_req_flag_i = unc;
    @(posedge clk); #1;
    bus.start_v_i = 1'b0;
  endtask

  // ways/states packed as {lce_odd, lce_even}
  task automatic beat(input logic [1:0] hits, input logic [5:0] ways, input logic [5:0] states);
    @(negedge clk);
    bus.beat_v_i      = 1'b1;
    bus.beat_hits_i   = hits;
    bus.beat_ways_i   = ways;
    bus.beat_states_i = states;
    @(posedge clk); #1;
    bus.beat_v_i    = 1'b0;
    bus.beat_hits_i = '0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic yumi_pulse();
    @(negedge clk);
    bus.yumi_i = 1'b1;
    @(posedge clk); #1;
    bus.yumi_i = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.start_v_i = 1'b0; bus.req_lce_i = '0; bus.req_type_flag_i = 1'b0;
    bus.lru_coh_state_i = '0; bus.atomic_req_flag_i = 1'b0; bus.uncached_req_flag_i = 1'b0;
    bus.beat_v_i = 1'b0; bus.beat_hits_i = '0; bus.beat_ways_i = '0; bus.beat_states_i = '0;
    bus.yumi_i = 1'b0;

    // Reset state
    #12;
    check("rst_start_ready", bus.start_ready_o, 1'b1);
    check("rst_beat_ready",  bus.beat_ready_o, 1'b0);
    check_out("rst", 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 5'b00000, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Owner in M: req 2 load; LCE3 S, LCE5 M way 4
    start_req(2, 1'b0, 0, 1'b0, 1'b0);
    check("m_beat_ready", bus.beat_ready_o, 1'b1);
    check("m_start_ready", bus.start_ready_o, 1'b0);
    beat(2'b00, 6'o00, 6'o00);
    beat(2'b10, 6'o00, 6'o10);
    beat(2'b10, 6'o40, 6'o60);
    check("m_v_early", bus.v_o, 1'b0);
    beat(2'b00, 6'o00, 6'o00);
    check_out("m", 1'b1, 0, 5, 4, 6, 1'b0, 1'b0, 5'b10100, 1'b0);
    yumi_pulse();
    check("m_v_after_yumi", bus.v_o, 1'b0);

    // Upgrade: req 0 store, LCE0 hits S way 2, lru M
    start_req(0, 1'b1, 6, 1'b0, 1'b0);
    beat(2'b01, 6'o02, 6'o01);
    beat(2'b00, 6'o00, 6'o00);
    beat(2'b00, 6'o00, 6'o00);
    beat(2'b00, 6'o00, 6'o00);
    check_out("upg", 1'b1, 2, 0, 0, 0, 1'b0, 1'b1, 5'b00000, 1'b0);
    yumi_pulse();

    // Uncached: req 7, LCE7 hits E way 1, beats every other cycle
    start_req(7, 1'b0, 0, 1'b0, 1'b1);
    idle_cycle();
    beat(2'b00, 6'o00, 6'o00);
    idle_cycle();
    beat(2'b00, 6'o00, 6'o00);
    idle_cycle();
    beat(2'b00, 6'o00, 6'o00);
    idle_cycle();
    check("unc_v_early", bus.v_o, 1'b0);
    beat(2'b10, 6'o10, 6'o20);
    check_out("unc", 1'b1, 1, 7, 1, 2, 1'b1, 1'b0, 5'b00000, 1'b0);
    // A beat presented while DONE must change nothing
    beat(2'b01, 6'o07, 6'o06);
    check_out("unc_ign", 1'b1, 1, 7, 1, 2, 1'b1, 1'b0, 5'b00000, 1'b0);
    yumi_pulse();

    // Multi-owner: req 0, LCE1 E way 3, LCE6 F way 5
    start_req(0, 1'b0, 0, 1'b0, 1'b0);
    beat(2'b10, 6'o30, 6'o20);
    beat(2'b00, 6'o00, 6'o00);
    beat(2'b00, 6'o00, 6'o00);
    beat(2'b01, 6'o05, 6'o03);
    check_out("multi", 1'b1, 0, 1, 3, 2, 1'b0, 1'b0, 5'b01001, 1'b1);
    yumi_pulse();

    // Reset mid-request after two beats that create an owner and a multi-owner error
    start_req(5, 1'b1, 6, 1'b0, 1'b0);
    beat(2'b10, 6'o70, 6'o60);
    beat(2'b10, 6'o20, 6'o70);
    rst = 1'b1;
    #2;
    check("mid_rst_start_ready", bus.start_ready_o, 1'b1);
    check("mid_rst_beat_ready",  bus.beat_ready_o, 1'b0);
    check_out("mid_rst", 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 5'b00000, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    // Fresh request: req 4 load, lru E, LCE2 S way 5
    start_req(4, 1'b0, 2, 1'b0, 1'b0);
    beat(2'b00, 6'o00, 6'o00);
    beat(2'b01, 6'o05, 6'o01);
    beat(2'b00, 6'o00, 6'o00);
    beat(2'b00, 6'o00, 6'o00);
    check_out("post_rst", 1'b1, 0, 0, 0, 0, 1'b1, 1'b0, 5'b10000, 1'b0);
    yumi_pulse();

    // Back-to-back: req 3 load lru S, LCE3 F way 6 (requestor is also owner)
    start_req(3, 1'b0, 1, 1'b0, 1'b0);
    beat(2'b00, 6'o00, 6'o00);
    beat(2'b10, 6'o60, 6'o30);
    beat(2'b00, 6'o00, 6'o00);
    beat(2'b00, 6'o00, 6'o00);
    check_out("b2b", 1'b1, 6, 3, 6, 3, 1'b0, 1'b0, 5'b00000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      check("hold_v",    bus.v_o, 1'b1);
      check("hold_oway", bus.owner_way_o, 3'd6);
      check("hold_rway", bus.req_addr_way_o, 3'd6);
    end
    // yumi and start together: start refused this cycle, taken the next
    @(negedge clk);
    bus.yumi_i = 1'b1;
    bus.start_v_i = 1'b1;
    bus.req_lce_i = 3'd0; bus.req_type_flag_i = 1'b0; bus.lru_coh_state_i = 3'd0;
    bus.atomic_req_flag_i = 1'b0; bus.uncached_req_flag_i = 1'b0;
    @(posedge clk); #1;
    bus.yumi_i = 1'b0;
    check("b2b_idle_start_ready", bus.start_ready_o, 1'b1);
    check("b2b_idle_beat_ready",  bus.beat_ready_o, 1'b0);
    check("b2b_idle_v",           bus.v_o, 1'b0);
    check("b2b_idle_olce_kept",   bus.owner_lce_o, 3'd3);
    @(posedge clk); #1;
    bus.start_v_i = 1'b0;
    check("b2b_acc_beat_ready",  bus.beat_ready_o, 1'b1);
    check("b2b_acc_start_ready", bus.start_ready_o, 1'b0);
    check("b2b_acc_olce_clr",    bus.owner_lce_o, 3'd0);
    check("b2b_acc_rway_clr",    bus.req_addr_way_o, 3'd0);
    beat(2'b00, 6'o00, 6'o00);
    beat(2'b00, 6'o00, 6'o00);
    beat(2'b00, 6'o00, 6'o00);
    beat(2'b00, 6'o00, 6'o00);
    check_out("b2b2", 1'b1, 0, 0, 0, 0, 1'b0, 1'b0, 5'b00000, 1'b0);
    yumi_pulse();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bp_cce_gad_stream.md
# bp_cce_gad_stream

Beat-serial, parametrised GAD engine for the CCE. It consumes one way-group's consolidated directory information over several beats of `lce_per_beat_p` LCEs each, and accumulates hit, owner and cached-state information in registers. It presents the auxiliary-directory flags, owner information and the requestor's way on a valid/yumi output. It sits between the directory read path and the CCE instruction decode/flag registers. It supports any valid MOESIF subset and flags multiple-owner coherence errors.

## Interface
- `num_lce_p`, default 8: LCEs tracked; must be a multiple of `lce_per_beat_p`.
- `lce_per_beat_p`, default 2: LCEs delivered per directory beat. Beats per request: `num_beats_lp = num_lce_p/lce_per_beat_p`.
- `lce_assoc_width_p`, default 3: way-index width.
- `lce_id_width_p`, default 3: LCE ID width; must be ≥ clog2(`num_lce_p`).
- `clk_i`, in, 1: the single clock.
- `reset_i`, in, 1: reset, asynchronous and active-high.
- `start_v_i`, in, 1: request details valid.
- `start_ready_o`, out, 1: high only in IDLE.
- `req_lce_i`, in, `lce_id_width_p`: requesting LCE.
- `req_type_flag_i`, in, 1: store miss.
- `lru_coh_state_i`, in, 3: `bp_coh_states_e` code. I=0, S=1, E=2, F=3, M=6, O=7.
- `atomic_req_flag_i`, in, 1: atomic request.
- `uncached_req_flag_i`, in, 1: uncached request.
- `beat_v_i`, in, 1: directory beat valid.
- `beat_ready_o`, out, 1: high only in COLLECT.
- `beat_hits_i`, in, `lce_per_beat_p`: per-LCE hit.
- `beat_ways_i`, in, `lce_per_beat_p`×`lce_assoc_width_p`: per-LCE way.
- `beat_states_i`, in, `lce_per_beat_p`×3: per-LCE coherence state.
- `v_o`, out, 1: result valid.
- `yumi_i`, in, 1: result consumed. Legal only when `v_o` is high.
- `req_addr_way_o`, out, `lce_assoc_width_p`: the requestor's hit way.
- `owner_lce_o`, out, `lce_id_width_p`: owner LCE ID.
- `owner_way_o`, out, `lce_assoc_width_p`: owner's way.
- `owner_coh_state_o`, out, 3: owner's coherence state.
- `replacement_flag_o`, `upgrade_flag_o`, out, 1 each: request flags.
- `cached_shared_flag_o`, `cached_exclusive_flag_o`, `cached_modified_flag_o`, `cached_owned_flag_o`, `cached_forward_flag_o`, out, 1 each: block cached in that state in some LCE other than the requestor.
- `multi_owner_error_o`, out, 1: more than one hitting LCE was in E, M, O or F.

## Operation
States and transitions:
- IDLE → COLLECT on `start_v_i & start_ready_o`.
  - Latch the request fields.
  - Clear all accumulators; the owner state clears to I.
  - Clear the beat counter.
- COLLECT: each `beat_v_i & beat_ready_o` processes LCEs `cnt*lce_per_beat_p + j`, for j = 0..`lce_per_beat_p`-1.
  - Hits with state S/E/M/O/F, at an LCE index ≠ `req_lce_i`, OR into the matching `cached_*` flag.
  - Index == `req_lce_i` and hit: latch `req_cached`, the way, and `req_ro`. `req_ro` is set when the state ∈ {S, F, O}.
  - Hit with state ∈ {E, M, O, F} is an owner candidate. The first candidate (lowest index, across and within beats) sets the owner LCE, way and state.
  - Any further owner candidate sets `multi_owner_error_o`; the owner already recorded is kept.
  - `cnt` increments per accepted beat. On the last beat (`cnt == num_beats_lp-1`), go to DONE and reset `cnt` to 0.
- DONE: `v_o` = 1 and all outputs are stable. On `yumi_i`, go to IDLE.
- Flags are computed registered on entry to DONE from the latched and accumulated values:
  - upgrade = `req_type_flag & req_ro & ~uncached`.
  - replacement:
    - If `uncached | atomic`: replacement = `req_cached`.
    - Otherwise: replacement = `~upgrade & (lru ∈ {E, M, O})`.
- `req_lce_i` ≥ `num_lce_p` never matches any index: `req_cached` = 0 and all hits count as "other".
- `req_addr_way_o` = 0 when not `req_cached`.
- If there is no owner: owner LCE = 0, owner way = 0, owner state = I.

## Timing
- Reset: async to IDLE.
  - All outputs 0, `owner_coh_state_o` = I (0).
  - `start_ready_o` = 1, `beat_ready_o` = 0, `v_o` = 0.
- Reset mid-COLLECT or in DONE discards the request with the same values.
- Beats are not accepted in the start cycle; the first beat can be accepted the cycle after the start handshake.
- Beats may stall (`beat_v_i` low) for any number of cycles; state is held.
- `v_o` rises the cycle after the last beat is accepted.
- Minimum start-to-`v_o` latency: `num_beats_lp`+1 cycles.
- Start and yumi in the same cycle: start is not accepted because `start_ready_o` is low in DONE. The next start is accepted the cycle after yumi.
- Outputs are held while `v_o` is high and `yumi_i` is low, and are not cleared on yumi; they clear at the next start.
- `beat_v_i` outside COLLECT is ignored.

## Test plan
All scenarios use 8 LCEs and 2 per beat.
- **Owner in M:** req LCE 2 loads. LCE 5 hits M way 4; LCE 3 hits S. → `v_o` 5 cycles after start. Owner 5 / way 4 / state M. `cached_modified_flag_o` = 1, `cached_shared_flag_o` = 1, upgrade = 0, error = 0.
- **Upgrade:** req LCE 0 store miss, LCE 0 hits S way 2, `lru_coh_state_i` = M. → upgrade = 1, replacement = 0, `req_addr_way_o` = 2, `cached_shared_flag_o` = 0.
- **Uncached request:** req LCE 7 uncached, LCE 7 hits E way 1, `beat_v_i` toggling every other cycle. → replacement = 1, upgrade = 0. Owner 7 / way 1 / state E. `v_o` rises after the 4th accepted beat.
- **Multi-owner error:** LCE 1 hits E and LCE 6 hits F. → owner = 1, `multi_owner_error_o` = 1.
- **Reset mid-request:** assert `reset_i` after 2 beats. → all outputs 0, owner state I, `start_ready_o` = 1. A new request then completes normally with no stale flags.
- **Back-to-back with held yumi:** hold `yumi_i` low for 3 cycles → outputs stable. Pulse `yumi_i` with `start_v_i` high → start is accepted one cycle later.
